// File: rtl/mem_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_ctrl_if
//  Purpose  : Multi-port line request/response bus between caches and mem_ctrl
//  Revision : 1.0  initial release
// ============================================================================
interface mem_ctrl_if #(
    parameter int NUM_PORTS = 2,
    parameter int LINE_LEN  = 128,
    parameter int ADDR_BITS = 32
);
    logic [NUM_PORTS-1:0]           req_valid;
    logic [NUM_PORTS-1:0]           req_ready;
    logic [NUM_PORTS-1:0]           req_write;
    logic [NUM_PORTS*ADDR_BITS-1:0] req_addr;
    logic [NUM_PORTS*LINE_LEN-1:0]  req_wdata;
    logic [NUM_PORTS-1:0]           resp_valid;
    logic [LINE_LEN-1:0]            resp_rdata;
    logic                           busy;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, busy
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, busy
    );
endinterface
`default_nettype wire

// File: rtl/mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mem_ctrl
//  Purpose  : Round-robin, one-at-a-time line memory with fixed access latency
//  Revision : 1.0  initial release
// ============================================================================
module mem_ctrl #(
    parameter int NUM_PORTS   = 2,
    parameter int LINE_LEN    = 128,
    parameter int ADDR_BITS   = 32,
    parameter int DEPTH_LINES = 1024,
    parameter int REQ_DELAY   = 5,
    parameter int RESP_DELAY  = 5
) (
    input wire logic  clk,
    input wire logic  reset,
    mem_ctrl_if.slave bus
);
    localparam int c_OFF  = $clog2(LINE_LEN / 8);
    localparam int c_IDX  = $clog2(DEPTH_LINES);
    localparam int c_PW   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int c_MAXD = (REQ_DELAY > RESP_DELAY) ? REQ_DELAY : RESP_DELAY;
    localparam int c_CW   = $clog2(c_MAXD + 1);
    localparam logic [ADDR_BITS-1:0] c_IDX_MASK =
        ADDR_BITS'(((64'd1 << c_IDX) - 64'd1) << c_OFF);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_REQ_WAIT  = 2'd1,
        S_RESP_WAIT = 2'd2,
        S_RESP      = 2'd3
    } state_t;

    state_t                 r_state;
    logic [c_CW-1:0]        r_cnt;
    logic [c_PW-1:0]        r_last;
    logic [c_PW-1:0]        r_port;
    logic                   r_write;
    logic [ADDR_BITS-1:0]   r_addr;
    logic [LINE_LEN-1:0]    r_wdata;
    logic [LINE_LEN-1:0]    r_resp;
    logic [NUM_PORTS-1:0]   r_resp_valid;
    logic                   r_busy;
    logic [LINE_LEN-1:0]    r_mem [DEPTH_LINES];

    logic                   w_any;
    logic [c_PW-1:0]        w_win;
    int                     w_best;
    int                     w_dist;
    logic [NUM_PORTS-1:0]   w_ready;
    logic                   w_sel_write;
    logic [ADDR_BITS-1:0]   w_sel_addr;
    logic [LINE_LEN-1:0]    w_sel_wdata;
    logic [c_IDX-1:0]       w_idx;
    logic                   w_access;
    logic                   w_commit;
    logic                   w_unused_addr;

    // Winner = requester with the smallest distance past the last grant.
    always_comb begin
        w_any  = 1'b0;
        w_win  = '0;
        w_best = NUM_PORTS;
        w_dist = 0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (bus.req_valid[i]) begin
                w_dist = (i + NUM_PORTS - 1 - int'(r_last)) % NUM_PORTS;
                if (w_dist < w_best) begin
                    w_best = w_dist;
                    w_win  = c_PW'(i);
                    w_any  = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_sel_write = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (w_win == c_PW'(p)) begin
                w_sel_write = bus.req_write[p];
                w_sel_addr  = bus.req_addr[p*ADDR_BITS +: ADDR_BITS];
                w_sel_wdata = bus.req_wdata[p*LINE_LEN +: LINE_LEN];
            end
        end
    end

    assign w_ready  = (r_state == S_IDLE && !reset && w_any) ? (NUM_PORTS'(1) << w_win) : '0;
    assign w_idx    = r_addr[c_OFF +: c_IDX];
    assign w_access = (r_state == S_REQ_WAIT) && (r_cnt == '0);
    // A reset on the access cycle must suppress the commit.
    assign w_commit = w_access && r_write && !reset;
    // Offset and upper address bits are intentionally ignored.
    assign w_unused_addr = |(r_addr & ~c_IDX_MASK);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_last       <= c_PW'(NUM_PORTS - 1);
            r_resp       <= '0;
            r_resp_valid <= '0;
            r_busy       <= 1'b0;
        end else begin
            r_resp_valid <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_port  <= w_win;
                        r_last  <= w_win;
                        r_write <= w_sel_write;
                        r_addr  <= w_sel_addr;
                        r_wdata <= w_sel_wdata;
                        r_cnt   <= c_CW'(REQ_DELAY - 1);
                        r_busy  <= 1'b1;
                        r_state <= S_REQ_WAIT;
                    end
                end
                S_REQ_WAIT: begin
                    if (r_cnt == '0) begin
                        r_resp <= r_write ? r_wdata : r_mem[w_idx];
                        if (RESP_DELAY == 1) begin
                            r_resp_valid <= NUM_PORTS'(1) << r_port;
                            r_state      <= S_RESP;
                        end else begin
                            r_cnt   <= c_CW'(RESP_DELAY - 2);
                            r_state <= S_RESP_WAIT;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_RESP_WAIT: begin
                    if (r_cnt == '0) begin
                        r_resp_valid <= NUM_PORTS'(1) << r_port;
                        r_state      <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_RESP: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_commit) begin
            r_mem[w_idx] <= r_wdata;
        end
    end

    assign bus.req_ready  = w_ready;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_rdata = r_resp;
    assign bus.busy       = r_busy;
endmodule
`default_nettype wire

// File: tb/tb_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_ctrl
//  Purpose  : Self-checking bench: directed scenarios plus random traffic
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_ctrl;
    localparam int NP  = 2;
    localparam int LL  = 128;
    localparam int AB  = 32;
    localparam int DL  = 1024;
    localparam int RD  = 5;
    localparam int SD  = 5;
    localparam int TOT = RD + SD;

    logic clk = 1'b0;
    logic rst;
    logic rst1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_ctrl_if #(.NUM_PORTS(NP), .LINE_LEN(LL), .ADDR_BITS(AB)) ifc ();
    mem_ctrl_if #(.NUM_PORTS(NP), .LINE_LEN(LL), .ADDR_BITS(AB)) ifc1 ();

    mem_ctrl #(.NUM_PORTS(NP), .LINE_LEN(LL), .ADDR_BITS(AB), .DEPTH_LINES(DL),
               .REQ_DELAY(RD), .RESP_DELAY(SD))
        dut (.clk(clk), .reset(rst), .bus(ifc));

    mem_ctrl #(.NUM_PORTS(NP), .LINE_LEN(LL), .ADDR_BITS(AB), .DEPTH_LINES(DL),
               .REQ_DELAY(1), .RESP_DELAY(1))
        dut1 (.clk(clk), .reset(rst1), .bus(ifc1));

    function automatic void check(string name, logic [127:0] act, logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endfunction

    function automatic void timeout(string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s @cycle %0d: timed out waiting for DUT", name, cyc);
    endfunction

    // ---------------- reference model of the default-parameter DUT ----------
    bit [LL-1:0]    m_mem [DL];
    bit             m_pend = 1'b0;
    bit             m_wr;
    int             m_acc, m_port, m_idx;
    int             m_last = NP - 1;
    logic [LL-1:0]  m_wdata, m_rdata;
    logic [NP-1:0]  e_rdy, e_rv;
    logic           e_busy;
    int             win;

    always @(negedge clk) begin
        if (cyc >= 1) begin
            win = -1;
            if (!m_pend && !rst) begin
                for (int k = 1; k <= NP; k++) begin
                    if (win < 0 && ifc.req_valid[(m_last + k) % NP]) win = (m_last + k) % NP;
                end
            end
            e_rdy = '0;
            if (win >= 0) e_rdy[win] = 1'b1;
            e_busy = m_pend && (cyc > m_acc);
            e_rv = '0;
            if (m_pend && cyc == m_acc + TOT) e_rv[m_port] = 1'b1;

            check("req_ready", 128'(ifc.req_ready), 128'(e_rdy));
            check("busy", 128'(ifc.busy), 128'(e_busy));
            check("resp_valid", 128'(ifc.resp_valid), 128'(e_rv));
            if (e_rv != '0) check("resp_rdata", ifc.resp_rdata, m_rdata);

            if (rst) begin
                m_pend = 1'b0;
                m_last = NP - 1;
            end else begin
                if (m_pend && m_wr && cyc == m_acc + RD) m_mem[m_idx] = m_wdata;
                if (m_pend && cyc == m_acc + TOT) m_pend = 1'b0;
                if (win >= 0) begin
                    m_pend  = 1'b1;
                    m_acc   = cyc;
                    m_port  = win;
                    m_last  = win;
                    m_wr    = ifc.req_write[win];
                    m_idx   = int'((ifc.req_addr[win*AB +: AB] / (LL / 8)) % DL);
                    m_wdata = ifc.req_wdata[win*LL +: LL];
                    m_rdata = m_wr ? m_wdata : m_mem[m_idx];
                end
            end
        end
    end

    // ---------------- stimulus helpers ---------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(int port, bit wr, logic [AB-1:0] addr, logic [LL-1:0] wd, output int acc);
        acc = -1;
        ifc.req_write[port]           = wr;
        ifc.req_addr[port*AB +: AB]   = addr;
        ifc.req_wdata[port*LL +: LL]  = wd;
        ifc.req_valid[port]           = 1'b1;
        for (int k = 0; k < 60 && acc < 0; k++) begin
            @(negedge clk);
            if (ifc.req_ready[port]) acc = cyc;
        end
        step();
        ifc.req_valid[port] = 1'b0;
        if (acc < 0) timeout("accept");
    endtask

    task automatic wait_resp(int port, output int rc, output logic [LL-1:0] rd);
        rc = -1;
        rd = '0;
        for (int k = 0; k < 40 && rc < 0; k++) begin
            @(negedge clk);
            if (ifc.resp_valid[port]) begin
                rc = cyc;
                rd = ifc.resp_rdata;
            end
        end
        step();
        if (rc < 0) timeout("resp_valid");
    endtask

    task automatic txn(int port, bit wr, logic [AB-1:0] addr, logic [LL-1:0] wd,
                       output int lat, output logic [LL-1:0] rd);
        int acc, rc;
        issue(port, wr, addr, wd, acc);
        wait_resp(port, rc, rd);
        lat = rc - acc;
    endtask

    task automatic txn1(int port, bit wr, logic [AB-1:0] addr, logic [LL-1:0] wd,
                        output int lat, output int bcnt, output logic [LL-1:0] rd);
        int acc;
        acc  = -1;
        lat  = -1;
        bcnt = 0;
        rd   = '0;
        ifc1.req_write[port]          = wr;
        ifc1.req_addr[port*AB +: AB]  = addr;
        ifc1.req_wdata[port*LL +: LL] = wd;
        ifc1.req_valid[port]          = 1'b1;
        for (int k = 0; k < 20 && acc < 0; k++) begin
            @(negedge clk);
            if (ifc1.req_ready[port]) acc = cyc;
        end
        step();
        ifc1.req_valid[port] = 1'b0;
        if (acc < 0) begin
            timeout("dut1_accept");
        end else begin
            for (int k = 0; k < 6; k++) begin
                @(negedge clk);
                if (ifc1.busy) bcnt++;
                if (ifc1.resp_valid[port]) begin
                    lat = cyc - acc;
                    rd  = ifc1.resp_rdata;
                end
            end
            step();
        end
    endtask

    task automatic new_payload(int p);
        ifc.req_write[p]        = 1'($urandom_range(0, 1));
        ifc.req_addr[p*AB +: AB] = ($urandom & 32'hFFFF_C00F) | (32'($urandom_range(0, 7)) << 4);
        ifc.req_wdata[p*LL +: LL] = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic run_random(int ncyc);
        logic [NP-1:0] accm;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            accm = ifc.req_valid & ifc.req_ready;
            step();
            rst = ($urandom_range(0, 399) == 0);
            for (int p = 0; p < NP; p++) begin
                if (accm[p]) ifc.req_valid[p] = 1'b0;
                else if (!ifc.req_valid[p]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        new_payload(p);
                        ifc.req_valid[p] = 1'b1;
                    end
                end else if ($urandom_range(0, 7) == 0) new_payload(p);
            end
        end
        rst = 1'b0;
        ifc.req_valid = '0;
    endtask

    // ---------------- main sequence ------------------------------------------
    localparam logic [LL-1:0] L1 = 128'hDEADBEEF_00000001_CAFEF00D_12345678;
    localparam logic [LL-1:0] L2 = 128'h0123456789ABCDEF_FEDCBA9876543210;
    localparam logic [LL-1:0] L3 = 128'h5555AAAA_5555AAAA_5555AAAA_5555AAAA;
    localparam logic [LL-1:0] L4 = 128'h00000000_11111111_22222222_33333333;

    int            lat, acc, bcnt, n, rvcnt;
    logic [LL-1:0] rd;
    int            gp [4];
    int            gc [4];

    initial begin
        rst  = 1'b1;
        rst1 = 1'b1;
        ifc.req_valid  = '0; ifc.req_write  = '0; ifc.req_addr  = '0; ifc.req_wdata  = '0;
        ifc1.req_valid = '0; ifc1.req_write = '0; ifc1.req_addr = '0; ifc1.req_wdata = '0;
        repeat (3) step();
        rst  = 1'b0;
        rst1 = 1'b0;
        @(negedge clk);
        check("reset_ready", 128'(ifc.req_ready), 128'(0));
        check("reset_busy", 128'(ifc.busy), 128'(0));
        check("reset_resp_valid", 128'(ifc.resp_valid), 128'(0));
        check("reset_rdata", ifc.resp_rdata, 128'(0));
        step();

        txn(0, 1'b0, 32'h1000, '0, lat, rd);
        check("rd1000_latency", 128'(lat), 128'(10));
        check("rd1000_data", rd, 128'(0));

        txn(1, 1'b1, 32'h40, L1, lat, rd);
        check("wr40_echo", rd, L1);
        txn(0, 1'b0, 32'h4C, '0, lat, rd);
        check("rd4C_data", rd, L1);
        check("rd4C_latency", 128'(lat), 128'(10));

        txn(1, 1'b1, 32'h0, L2, lat, rd);
        txn(0, 1'b0, DL * 16, '0, lat, rd);
        check("wrap_data", rd, L2);

        // Reset three cycles into a write: no response, no commit.
        issue(0, 1'b1, 32'h80, L3, acc);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        rvcnt = 0;
        repeat (15) begin
            @(negedge clk);
            if (ifc.resp_valid != '0) rvcnt++;
        end
        step();
        check("abort_no_resp", 128'(rvcnt), 128'(0));
        txn(0, 1'b0, 32'h80, '0, lat, rd);
        check("abort_not_committed", rd, 128'(0));

        // Both ports held valid out of reset.
        rst = 1'b1;
        ifc.req_write = '0;
        ifc.req_addr  = {32'h200, 32'h100};
        ifc.req_valid = 2'b11;
        step();
        rst = 1'b0;
        n = 0;
        for (int k = 0; k < 4; k++) begin gp[k] = -1; gc[k] = 0; end
        for (int k = 0; k < 200 && n < 4; k++) begin
            @(negedge clk);
            if ((ifc.req_valid & ifc.req_ready) != '0) begin
                gp[n] = ifc.req_ready[1] ? 1 : 0;
                gc[n] = cyc;
                n++;
            end
        end
        step();
        ifc.req_valid = '0;
        if (n < 4) timeout("rr_accepts");
        check("rr_grant0", 128'(gp[0]), 128'(0));
        check("rr_grant1", 128'(gp[1]), 128'(1));
        check("rr_grant2", 128'(gp[2]), 128'(0));
        check("rr_grant3", 128'(gp[3]), 128'(1));
        for (int k = 1; k < 4; k++) check("rr_spacing", 128'(gc[k] - gc[k-1]), 128'(11));
        repeat (12) step();

        run_random(1500);
        repeat (12) step();

        txn1(0, 1'b0, 32'h200, '0, lat, bcnt, rd);
        check("d1_rd_latency", 128'(lat), 128'(2));
        check("d1_rd_busy", 128'(bcnt), 128'(2));
        check("d1_rd_data", rd, 128'(0));
        txn1(1, 1'b1, 32'h30, L4, lat, bcnt, rd);
        check("d1_wr_latency", 128'(lat), 128'(2));
        check("d1_wr_echo", rd, L4);
        txn1(0, 1'b0, 32'h3C, '0, lat, bcnt, rd);
        check("d1_rdback", rd, L4);
        check("d1_rdback_busy", 128'(bcnt), 128'(2));

        repeat (5) step();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 The block SHALL take parameter NUM_PORTS, default 2, the number of requesters (port 0 = icache, port 1 = dcache).
REQ-002 The block SHALL take parameter LINE_LEN, default 128, the line width in bits; a multiple of 8 and a power of 2.
REQ-003 The block SHALL take parameter ADDR_BITS, default 32, the request address width in bits.
REQ-004 The block SHALL take parameter DEPTH_LINES, default 1024, the number of stored lines; a power of 2.
REQ-005 The block SHALL take parameter REQ_DELAY, default 5, the cycles from accept to array access; legal range >= 1.
REQ-006 The block SHALL take parameter RESP_DELAY, default 5, the cycles from array access to response; legal range >= 1.
REQ-007 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-008 The block SHALL have port reset, input, 1 bit: the reset, synchronous and active-high.
REQ-009 The block SHALL have port req_valid, input, NUM_PORTS bits: a per-port request, held until accepted.
REQ-010 The block SHALL have port req_ready, output, NUM_PORTS bits: a per-port accept; at most one bit set.
REQ-011 The block SHALL have port req_write, input, NUM_PORTS bits: per port, 1 = line write and 0 = line read.
REQ-012 The block SHALL have port req_addr, input, NUM_PORTS*ADDR_BITS bits: the packed byte addresses, port p at slice [p*ADDR_BITS +: ADDR_BITS].
REQ-013 The block SHALL have port req_wdata, input, NUM_PORTS*LINE_LEN bits: the packed write lines.
REQ-014 The block SHALL have port resp_valid, output, NUM_PORTS bits: a one-cycle per-port completion pulse.
REQ-015 The block SHALL have port resp_rdata, output, LINE_LEN bits: the response line, shared by all ports and qualified by resp_valid.
REQ-016 The block SHALL have port busy, output, 1 bit: high whenever the block is not in IDLE.

Function
REQ-017 The controller SHALL serve one transaction at a time through the FSM path IDLE -> REQ_WAIT -> RESP_WAIT -> RESP -> IDLE.
REQ-018 In IDLE only, req_ready SHALL be one-hot on the arbitration winner whenever any req_valid is set, and all zero otherwise (combinational from req_valid and the round-robin pointer).
REQ-019 Arbitration SHALL be round-robin: the winner is the first requesting port after last_grant, in increasing index order with wrap to 0.
REQ-020 An accept SHALL occur when req_valid[p] & req_ready[p]; on accept, the controller latches the port, write flag, address and wdata, sets last_grant = p, and moves to REQ_WAIT.
REQ-021 REQ_WAIT SHALL last exactly REQ_DELAY cycles, counted by a down-counter.
REQ-022 On REQ_WAIT's final cycle, the controller SHALL read the array into the response register; for a write, it SHALL also write the latched line into the array and load that same line into the response register.
REQ-023 RESP_WAIT SHALL last exactly RESP_DELAY-1 cycles (zero cycles when RESP_DELAY = 1), followed by one RESP cycle.
REQ-024 In RESP, resp_valid[latched port] SHALL be 1 for exactly that cycle, with resp_rdata driving the response register.
REQ-025 Latency SHALL be fixed: an accept at cycle T yields resp_valid at cycle T+REQ_DELAY+RESP_DELAY.
REQ-026 The earliest next accept SHALL be the cycle after RESP.
REQ-027 The response SHALL have no backpressure; a requester must sample it in the RESP cycle.
REQ-028 The line index SHALL be addr[OFF +: IDX], where OFF = $clog2(LINE_LEN/8) and IDX = $clog2(DEPTH_LINES); the low OFF bits and the bits above OFF+IDX are ignored, so addresses wrap modulo the array size.
REQ-029 Changes on req_* inputs outside the accept cycle SHALL have no effect on the transaction in flight.
REQ-030 While busy, the controller SHALL hold all req_ready bits at 0; pending requests wait and are not lost.
REQ-031 A read to a line written earlier SHALL return the written data; the write is committed before any later transaction's access.
REQ-032 resp_rdata SHALL hold its last value outside RESP.

Reset
REQ-033 While reset is high, the FSM SHALL go to IDLE, the counter to 0, last_grant to NUM_PORTS-1 (port 0 wins first), the response register to 0, resp_valid to 0, and busy to 0.
REQ-034 Reset mid-transaction SHALL abort it with no resp_valid; a write whose commit cycle has not been reached is not committed.
REQ-035 Array contents SHALL be unaffected by reset; the array is zero at time 0 only.

Verification
REQ-036 The bench SHALL cover: reset release, then port 0 reads 0x1000 at cycle T -> resp_valid[0] at T+10 with resp_rdata = 0.
REQ-037 The bench SHALL cover: port 1 writes 0xDEADBEEF_00000001_CAFEF00D_12345678 to 0x40, then port 0 reads 0x4C -> second response returns the same line (same index, offset ignored).
REQ-038 The bench SHALL cover: ports 0 and 1 both holding req_valid from reset -> grants alternate 0,1,0,1 with accepts spaced 11 cycles apart.
REQ-039 The bench SHALL cover: a write to 0x0 and a read of DEPTH_LINES*16 (0x4000 at defaults) -> the read returns the written line (address wrap).
REQ-040 The bench SHALL cover: reset asserted 3 cycles after accepting a write to 0x80 -> no resp_valid, and a later read of 0x80 returns 0.
REQ-041 The bench SHALL cover: REQ_DELAY=1, RESP_DELAY=1 build -> read response exactly 2 cycles after accept, and busy high for exactly 2 cycles.
